// File: rtl/lsu_bus_if.sv
// Core-side request/response and memory-bus signals of the load/store bus unit.
// The unit itself uses the master modport; the core/bus environment uses slave.
interface lsu_bus_if;
  logic        rmem;
  logic        wmem;
  logic [1:0]  mem_type;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    input  rmem, wmem, mem_type, mem_sign, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
    output rdata, busy, done, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output rmem, wmem, mem_type, mem_sign, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
    input  rdata, busy, done, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu_bus.sv
// Load/store bus unit: turns core rmem/wmem accesses into a req/gnt/rvalid bus
// transaction, returns aligned and extended load data, and stalls the core.
module lsu_bus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rstn,
  lsu_bus_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      type_q;
  logic            sign_q;
  logic [1:0]      off_q;
  logic            bus_req_q, bus_we_q, done_q, err_q;
  logic [31:0]     bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]      bus_be_q;

  logic            req_valid, fault, tmo;
  logic [CntW-1:0] cnt_inc;
  logic [3:0]      be_d;
  logic [31:0]     wdata_d, load_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Request decode: fault detection and byte-lane steering of the store data.
  always_comb begin
    req_valid = bus.rmem | bus.wmem;
    fault     = (bus.rmem & bus.wmem) | (bus.mem_type == 2'b11) |
                ((bus.mem_type == 2'b01) & bus.addr[0]) |
                ((bus.mem_type == 2'b10) & (|bus.addr[1:0]));
    be_d      = 4'b1111;
    wdata_d   = bus.wdata;
    unique case (bus.mem_type)
      2'b00: begin
        be_d    = 4'b0001 << bus.addr[1:0];
        wdata_d = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << bus.addr[1:0];
        wdata_d = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction from the returned word using the latched size/offset/sign.
  always_comb begin
    ld_byte  = bus.bus_rdata[{off_q, 3'b000} +: 8];
    ld_half  = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    load_ext = bus.bus_rdata;
    unique case (type_q)
      2'b00:   load_ext = sign_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = sign_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Timeout fires on the TIMEOUT-th REQ/WAIT cycle that has no completing event.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    tmo     = (cnt_inc >= CntMax);
  end

  // Transaction FSM with registered bus/core outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      type_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cnt_q <= '0;
            if (fault) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= StReq;
              bus_req_q   <= 1'b1;
              bus_we_q    <= bus.wmem;
              bus_addr_q  <= {bus.addr[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              type_q      <= bus.mem_type;
              sign_q      <= bus.mem_sign;
              off_q       <= bus.addr[1:0];
            end
          end
        end
        StReq: begin
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            if (bus_we_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
            end else if (bus.bus_rvalid) begin
              state_q <= StDone;
              rdata_q <= load_ext;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
            end else if (tmo) begin
              state_q <= StDone;
              rdata_q <= '0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= cnt_inc;
            end
          end else if (tmo) begin
            state_q   <= StDone;
            bus_req_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWait: begin
          if (bus.bus_rvalid) begin
            state_q <= StDone;
            rdata_q <= load_ext;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
          end else if (tmo) begin
            state_q <= StDone;
            rdata_q <= '0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the core holds on the very cycle it raises a request;
  // gated by reset so it drops immediately when reset asserts.
  always_comb begin
    bus.busy = rstn & ((state_q == StReq) | (state_q == StWait) |
                       ((state_q == StIdle) & req_valid));
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Bench for lsu_bus: directed scenarios plus randomized accesses checked against
// a behavioural model of lane steering, load extension, faults and latency.
module tb_lsu_bus;
  localparam int unsigned Tmo = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lsu_bus_if bif ();

  lsu_bus #(.TIMEOUT(Tmo)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bif.rmem       = 1'b0;
    bif.wmem       = 1'b0;
    bif.mem_type   = 2'b00;
    bif.mem_sign   = 1'b0;
    bif.addr       = '0;
    bif.wdata      = '0;
    bif.bus_gnt    = 1'b0;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata  = '0;
  endtask

  // Model: access fault rules.
  function automatic logic m_fault(input logic rm, input logic wm, input logic [1:0] typ,
                                   input logic [31:0] a);
    if (rm && wm) return 1'b1;
    if (typ == 2'd3) return 1'b1;
    if (typ == 2'd1 && (a % 2) != 0) return 1'b1;
    if (typ == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] typ, input int off);
    if (typ == 2'd0) return 4'(1 << off);
    if (typ == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] typ, input logic [31:0] wd);
    logic [31:0] b;
    logic [31:0] h;
    b = wd & 32'hFF;
    h = wd & 32'hFFFF;
    if (typ == 2'd0) return b * 32'h0101_0101;
    if (typ == 2'd1) return h * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdin, input logic [1:0] typ,
                                         input logic sgn, input int off);
    logic [31:0] v;
    v = rdin >> (8 * off);
    if (typ == 2'd0) begin
      v = v & 32'hFF;
      if (!sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (typ == 2'd1) begin
      v = v & 32'hFFFF;
      if (!sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rdin;
    end
    return v;
  endfunction

  // Drives one access (sampled in cycle 0), grants gd REQ cycles late, returns read data
  // rd cycles after the grant (0 = same cycle); records what the DUT does.
  task automatic run_access(
    input  logic rm, input logic wm, input logic [1:0] typ, input logic sgn,
    input  logic [31:0] a, input logic [31:0] wd, input int gd, input int rd,
    input  logic [31:0] rdin,
    output int lat, output int req_cyc, output int busy_cyc, output logic err_o,
    output logic [31:0] rd_o, output logic [31:0] addr_o, output logic [3:0] be_o,
    output logic [31:0] wd_o, output logic we_o);
    logic seen;
    lat = -1; req_cyc = 0; busy_cyc = 0; err_o = 1'bx; rd_o = 'x;
    addr_o = 'x; be_o = 'x; wd_o = 'x; we_o = 1'bx; seen = 1'b0;
    next_cyc();
    bif.rmem = rm; bif.wmem = wm; bif.mem_type = typ; bif.mem_sign = sgn;
    bif.addr = a; bif.wdata = wd;
    @(negedge clk);
    if (bif.busy) busy_cyc++;
    for (int c = 1; c <= 20; c++) begin
      next_cyc();
      if (bif.done) begin
        bif.rmem = 1'b0;
        bif.wmem = 1'b0;
      end
      bif.bus_gnt    = (c == gd + 1);
      bif.bus_rvalid = rm && !wm && (c == gd + 1 + rd);
      bif.bus_rdata  = bif.bus_rvalid ? rdin : $urandom;
      @(negedge clk);
      if (bif.busy) busy_cyc++;
      if (bif.bus_req) begin
        if (!seen) begin
          addr_o = bif.bus_addr; be_o = bif.bus_be; wd_o = bif.bus_wdata; we_o = bif.bus_we;
        end
        seen = 1'b1;
        req_cyc++;
      end
      if (bif.done) begin
        lat   = c;
        err_o = bif.err;
        rd_o  = bif.rdata;
        break;
      end
    end
    next_cyc();
    idle_in();
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int          lat, req_cyc, busy_cyc, gd, rd, sel;
    logic        err_o, we_o, rm, wm, sgn, f;
    logic [31:0] rd_o, addr_o, wd_o, a, wd, rdin, exp_rdata;
    logic [3:0]  be_o;
    logic [1:0]  typ;

    idle_in();
    rstn = 1'b0;
    exp_rdata = '0;
    #1;
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_done", 32'(bif.done), 0);
    chk("rst_err", 32'(bif.err), 0);
    chk("rst_req", 32'(bif.bus_req), 0);
    chk("rst_rdata", bif.rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Signed byte load, zero-wait bus.
    run_access(1, 0, 2'd0, 0, 32'h1003, 0, 0, 1, 32'h80FF_0000,
               lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
    chk("sb_lat", 32'(lat), 3);
    chk("sb_busy", 32'(busy_cyc), 3);
    chk("sb_reqcyc", 32'(req_cyc), 1);
    chk("sb_be", 32'(be_o), 32'b1000);
    chk("sb_addr", addr_o, 32'h1000);
    chk("sb_we", 32'(we_o), 0);
    chk("sb_err", 32'(err_o), 0);
    chk("sb_rdata", rd_o, 32'hFFFF_FF80);
    @(negedge clk);
    chk("sb_done_pulse", 32'(bif.done), 0);
    chk("sb_rdata_hold", bif.rdata, 32'hFFFF_FF80);

    // Unsigned half load from the upper half.
    run_access(1, 0, 2'd1, 1, 32'h2, 0, 0, 1, 32'hBEEF_1234,
               lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
    chk("uh_rdata", rd_o, 32'h0000_BEEF);
    chk("uh_be", 32'(be_o), 32'b1100);
    exp_rdata = 32'h0000_BEEF;

    // Byte store, zero-wait grant.
    run_access(0, 1, 2'd0, 0, 32'h5, 32'hAB, 0, 0, 0,
               lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
    chk("st_lat", 32'(lat), 2);
    chk("st_addr", addr_o, 32'h4);
    chk("st_be", 32'(be_o), 32'b0010);
    chk("st_wdata", wd_o, 32'hABAB_ABAB);
    chk("st_we", 32'(we_o), 1);
    chk("st_rdata_keep", rd_o, exp_rdata);

    // Faults: misaligned word, read+write together, reserved size.
    for (int k = 0; k < 3; k++) begin
      rm = (k != 0) ? 1'b1 : 1'b1;
      wm = (k == 1);
      typ = (k == 2) ? 2'd3 : 2'd2;
      a = (k == 0) ? 32'h6 : 32'h8;
      run_access(rm, wm, typ, 0, a, 32'h1234_5678, 99, 99, 0,
                 lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
      chk($sformatf("flt%0d_lat", k), 32'(lat), 1);
      chk($sformatf("flt%0d_err", k), 32'(err_o), 1);
      chk($sformatf("flt%0d_req", k), 32'(req_cyc), 0);
      chk($sformatf("flt%0d_rdata", k), rd_o, exp_rdata);
    end

    // Timeout: grant never comes.
    run_access(1, 0, 2'd2, 0, 32'h40, 0, 99, 0, 0,
               lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
    chk("tmo_req", 32'(req_cyc), Tmo);
    chk("tmo_lat", 32'(lat), Tmo + 1);
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_rdata", rd_o, 0);
    chk("tmo_busy", 32'(busy_cyc), Tmo + 1);
    exp_rdata = '0;

    // Grant withheld 3 cycles then given: completes normally.
    run_access(0, 1, 2'd2, 0, 32'h80, 32'hCAFE_F00D, 3, 0, 0,
               lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
    chk("late_w_lat", 32'(lat), 5);
    chk("late_w_err", 32'(err_o), 0);
    chk("late_w_wdata", wd_o, 32'hCAFE_F00D);
    run_access(1, 0, 2'd2, 0, 32'h84, 0, 3, 0, 32'h1357_9BDF,
               lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
    chk("late_r_lat", 32'(lat), 5);
    chk("late_r_err", 32'(err_o), 0);
    chk("late_r_rdata", rd_o, 32'h1357_9BDF);
    exp_rdata = 32'h1357_9BDF;

    // Reset pulsed during WAIT.
    next_cyc();
    bif.rmem = 1'b1; bif.mem_type = 2'd2; bif.addr = 32'h100;
    next_cyc();
    bif.bus_gnt = 1'b1;
    next_cyc();
    bif.bus_gnt = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rstw_req", 32'(bif.bus_req), 0);
    chk("rstw_busy", 32'(bif.busy), 0);
    chk("rstw_done", 32'(bif.done), 0);
    @(negedge clk);
    rstn = 1'b1;
    bif.rmem = 1'b0;
    exp_rdata = '0;
    next_cyc();
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    chk("rstw_late_done0", 32'(bif.done), 0);
    next_cyc();
    bif.bus_rvalid = 1'b0;
    @(negedge clk);
    chk("rstw_late_done1", 32'(bif.done), 0);
    chk("rstw_rdata", bif.rdata, exp_rdata);
    run_access(1, 0, 2'd0, 1, 32'h101, 0, 0, 1, 32'h0000_C300,
               lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
    chk("rstw_new_lat", 32'(lat), 3);
    chk("rstw_new_rdata", rd_o, 32'h0000_00C3);
    exp_rdata = 32'h0000_00C3;

    // Randomized accesses against the model.
    for (int it = 0; it < 40; it++) begin
      sel  = $urandom_range(0, 9);
      rm   = (sel < 5) || (sel == 9);
      wm   = (sel >= 5);
      typ  = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      wd   = $urandom;
      rdin = $urandom;
      gd   = $urandom_range(0, 1);
      rd   = $urandom_range(0, 1);
      f    = m_fault(rm, wm, typ, a);
      run_access(rm, wm, typ, sgn, a, wd, gd, rd, rdin,
                 lat, req_cyc, busy_cyc, err_o, rd_o, addr_o, be_o, wd_o, we_o);
      if (f) begin
        chk($sformatf("rnd%0d_lat", it), 32'(lat), 1);
        chk($sformatf("rnd%0d_req", it), 32'(req_cyc), 0);
      end else begin
        if (rm) exp_rdata = m_load(rdin, typ, sgn, int'(a % 4));
        chk($sformatf("rnd%0d_lat", it), 32'(lat), rm ? gd + rd + 2 : gd + 2);
        chk($sformatf("rnd%0d_req", it), 32'(req_cyc), gd + 1);
        chk($sformatf("rnd%0d_addr", it), addr_o, a - (a % 4));
        chk($sformatf("rnd%0d_be", it), 32'(be_o), 32'(m_be(typ, int'(a % 4))));
        chk($sformatf("rnd%0d_we", it), 32'(we_o), 32'(wm));
        if (wm) chk($sformatf("rnd%0d_wdata", it), wd_o, m_wdata(typ, wd));
      end
      chk($sformatf("rnd%0d_err", it), 32'(err_o), 32'(f));
      chk($sformatf("rnd%0d_rdata", it), rd_o, exp_rdata);
      chk($sformatf("rnd%0d_busy", it), 32'(busy_cyc), 32'(lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
